// File: rtl/csr_decoder_pkg.sv
// Shared sparse-matrix definitions: default word/address/index widths and
// the CSR decoder state encoding.
package csr_decoder_pkg;

    localparam int CSR_DATA_W = 32;
    localparam int CSR_ADDR_W = 14;
    localparam int CSR_DIM_W  = 10;

    typedef logic [2:0] csr_state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PTR_LO   = 3'd1;
    localparam logic [2:0] ST_PTR_HI   = 3'd2;
    localparam logic [2:0] ST_FETCH    = 3'd3;
    localparam logic [2:0] ST_WAIT     = 3'd4;
    localparam logic [2:0] ST_EMIT     = 3'd5;
    localparam logic [2:0] ST_NEXT_ROW = 3'd6;
    localparam logic [2:0] ST_FIN      = 3'd7;

endpackage

// File: rtl/csr_decoder.sv
// Expands CSR storage (row_ptr/col/val RAMs, 1-cycle synchronous reads) into a
// row-major dense element stream with a valid/ready output handshake.
module csr_decoder
    import csr_decoder_pkg::*;
#(
    parameter int DATA_W = CSR_DATA_W,
    parameter int ADDR_W = CSR_ADDR_W,
    parameter int DIM_W  = CSR_DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DIM_W-1:0]  i_n_rows,
    input  logic [DIM_W-1:0]  i_n_cols,
    output logic [ADDR_W-1:0] o_row_addr,
    input  logic [DATA_W-1:0] i_row_dout,
    output logic [ADDR_W-1:0] o_col_addr,
    input  logic [DATA_W-1:0] i_col_dout,
    output logic [ADDR_W-1:0] o_val_addr,
    input  logic [DATA_W-1:0] i_val_dout,
    output logic [DATA_W-1:0] o_out_data,
    output logic [DIM_W-1:0]  o_out_row,
    output logic [DIM_W-1:0]  o_out_col,
    output logic              o_out_zero,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    csr_state_t        r_state;
    logic [DIM_W-1:0]  r_n_rows, r_n_cols, r_r, r_c;
    logic [ADDR_W-1:0] r_k, r_hi, r_row_addr, r_col_addr, r_val_addr;
    logic              r_hi_pend, r_live;
    logic [DATA_W-1:0] r_ent_col, r_ent_val;
    logic [DATA_W-1:0] r_out_data;
    logic [DIM_W-1:0]  r_out_row, r_out_col;
    logic              r_out_zero, r_out_valid, r_busy, r_done, r_err;

    logic [ADDR_W-1:0] w_hi, w_k_inc, w_k_after;
    logic [DIM_W-1:0]  w_c_inc;
    logic [DATA_W-1:0] w_c_ext, w_c_inc_ext, w_n_cols_ext;
    logic              w_hs, w_last_col, w_last_row, w_wait_hit, w_next_hit;
    logic              w_unused;

    // row_ptr[r+1] arrives during the first FETCH of a row; later FETCHes use the latched copy
    assign w_hi         = r_hi_pend ? i_row_dout[ADDR_W-1:0] : r_hi;
    assign w_k_inc      = r_k + ADDR_W'(1);
    assign w_k_after    = r_out_zero ? r_k : w_k_inc;
    assign w_c_inc      = r_c + DIM_W'(1);
    assign w_c_ext      = DATA_W'(r_c);
    assign w_c_inc_ext  = DATA_W'(w_c_inc);
    assign w_n_cols_ext = DATA_W'(r_n_cols);
    assign w_hs         = r_out_valid && i_out_ready;
    assign w_last_col   = (r_c == r_n_cols - DIM_W'(1));
    assign w_last_row   = (r_r == r_n_rows - DIM_W'(1));
    assign w_wait_hit   = (i_col_dout == w_c_ext);
    assign w_next_hit   = r_live && (r_ent_col == w_c_inc_ext);
    assign w_unused     = ^i_row_dout[DATA_W-1:ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_n_rows    <= '0;
            r_n_cols    <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_k         <= '0;
            r_hi        <= '0;
            r_row_addr  <= '0;
            r_col_addr  <= '0;
            r_val_addr  <= '0;
            r_hi_pend   <= 1'b0;
            r_live      <= 1'b0;
            r_ent_col   <= '0;
            r_ent_val   <= '0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_zero  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_n_rows   <= i_n_rows;
                        r_n_cols   <= i_n_cols;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_r        <= '0;
                        r_c        <= '0;
                        r_k        <= '0;
                        r_hi       <= '0;
                        r_live     <= 1'b0;
                        r_row_addr <= '0;
                        if (i_n_rows == '0 || i_n_cols == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_PTR_LO;
                        end
                    end
                end
                ST_PTR_LO: begin
                    r_row_addr <= ADDR_W'(r_r) + ADDR_W'(1);
                    r_state    <= ST_PTR_HI;
                end
                ST_PTR_HI: begin
                    r_k        <= i_row_dout[ADDR_W-1:0];
                    r_col_addr <= i_row_dout[ADDR_W-1:0];
                    r_val_addr <= i_row_dout[ADDR_W-1:0];
                    r_hi_pend  <= 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_hi_pend <= 1'b0;
                    r_hi      <= w_hi;
                    if (r_k < w_hi) begin
                        r_state <= ST_WAIT;
                    end else begin
                        // no entries left in this row: the current column is an implicit zero
                        if (w_hi < r_k)
                            r_err <= 1'b1;
                        r_live      <= 1'b0;
                        r_out_data  <= '0;
                        r_out_zero  <= 1'b1;
                        r_out_row   <= r_r;
                        r_out_col   <= r_c;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_EMIT;
                    end
                end
                ST_WAIT: begin
                    r_ent_col <= i_col_dout;
                    r_ent_val <= i_val_dout;
                    if (i_col_dout < w_c_ext) begin
                        r_err      <= 1'b1;
                        r_live     <= 1'b0;
                        r_k        <= w_k_inc;
                        r_col_addr <= w_k_inc;
                        r_val_addr <= w_k_inc;
                        r_state    <= ST_FETCH;
                    end else begin
                        // an out-of-range column drops the rest of the row
                        if (i_col_dout >= w_n_cols_ext)
                            r_err <= 1'b1;
                        r_live      <= (i_col_dout < w_n_cols_ext);
                        r_out_data  <= w_wait_hit ? i_val_dout : '0;
                        r_out_zero  <= !w_wait_hit;
                        r_out_row   <= r_r;
                        r_out_col   <= r_c;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_hs) begin
                        if (w_last_col) begin
                            if (w_k_after < r_hi)
                                r_err <= 1'b1;
                            r_k         <= w_k_after;
                            r_live      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_state     <= ST_NEXT_ROW;
                        end else if (!r_out_zero) begin
                            r_c         <= w_c_inc;
                            r_k         <= w_k_inc;
                            r_col_addr  <= w_k_inc;
                            r_val_addr  <= w_k_inc;
                            r_live      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_state     <= ST_FETCH;
                        end else begin
                            r_c        <= w_c_inc;
                            r_out_col  <= w_c_inc;
                            r_out_data <= w_next_hit ? r_ent_val : '0;
                            r_out_zero <= !w_next_hit;
                        end
                    end
                end
                ST_NEXT_ROW: begin
                    if (w_last_row) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_r        <= r_r + DIM_W'(1);
                        r_c        <= '0;
                        r_row_addr <= ADDR_W'(r_r) + ADDR_W'(1);
                        r_state    <= ST_PTR_LO;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_row_addr  = r_row_addr;
    assign o_col_addr  = r_col_addr;
    assign o_val_addr  = r_val_addr;
    assign o_out_data  = r_out_data;
    assign o_out_row   = r_out_row;
    assign o_out_col   = r_out_col;
    assign o_out_zero  = r_out_zero;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_csr_decoder.sv
// Self-checking bench for csr_decoder: RAM models, a dense-expansion reference
// model, directed CSR cases and randomized matrices with random back-pressure.
module tb_csr_decoder;

    typedef struct packed {
        logic [31:0] data;
        logic [9:0]  row;
        logic [9:0]  col;
        logic        zero;
    } elem_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [9:0]  i_n_rows = '0;
    logic [9:0]  i_n_cols = '0;
    logic [13:0] o_row_addr, o_col_addr, o_val_addr;
    logic [31:0] i_row_dout = '0, i_col_dout = '0, i_val_dout = '0;
    logic [31:0] o_out_data;
    logic [9:0]  o_out_row, o_out_col;
    logic        o_out_zero, o_out_valid;
    logic        i_out_ready = 1'b1;
    logic        o_busy, o_done, o_err;

    logic [31:0] row_mem [0:63];
    logic [31:0] col_mem [0:63];
    logic [31:0] val_mem [0:63];

    int    checks = 0;
    int    failures = 0;
    elem_t exp_q[$];
    elem_t obs_q[$];
    bit    exp_err;
    int    done_cnt, done_cyc, done_hs, stall_bad;
    bit    timed_out, busy_at_done, busy_after;

    csr_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_n_rows    (i_n_rows),
        .i_n_cols    (i_n_cols),
        .o_row_addr  (o_row_addr),
        .i_row_dout  (i_row_dout),
        .o_col_addr  (o_col_addr),
        .i_col_dout  (i_col_dout),
        .o_val_addr  (o_val_addr),
        .i_val_dout  (i_val_dout),
        .o_out_data  (o_out_data),
        .o_out_row   (o_out_row),
        .o_out_col   (o_out_col),
        .o_out_zero  (o_out_zero),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        i_row_dout <= row_mem[o_row_addr[5:0]];
        i_col_dout <= col_mem[o_col_addr[5:0]];
        i_val_dout <= val_mem[o_val_addr[5:0]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            row_mem[i] = 32'd0;
            col_mem[i] = 32'd0;
            val_mem[i] = 32'd0;
        end
    endtask

    task automatic load_spec();
        clear_mem();
        row_mem[0] = 32'd0; row_mem[1] = 32'd1; row_mem[2] = 32'd2; row_mem[3] = 32'd2;
        col_mem[0] = 32'd0; col_mem[1] = 32'd2;
        val_mem[0] = 32'd5; val_mem[1] = 32'd7;
    endtask

    // Reference: dense expansion of each row, walking the row's entries in order
    task automatic build_expected(input int nr, input int nc);
        int unsigned k, hi;
        elem_t e;
        exp_q.delete();
        exp_err = 1'b0;
        for (int r = 0; r < nr; r++) begin
            k  = row_mem[r] & 32'h3FFF;
            hi = row_mem[r+1] & 32'h3FFF;
            if (hi < k) exp_err = 1'b1;
            for (int unsigned c = 0; c < nc; c++) begin
                while (k < hi && col_mem[k] < c) begin
                    exp_err = 1'b1;
                    k++;
                end
                if (k < hi && col_mem[k] >= nc) begin
                    exp_err = 1'b1;
                    k = hi;
                end
                e.row = 10'(r);
                e.col = 10'(c);
                if (k < hi && col_mem[k] == c) begin
                    e.data = val_mem[k];
                    e.zero = 1'b0;
                    k++;
                end else begin
                    e.data = 32'd0;
                    e.zero = 1'b1;
                end
                exp_q.push_back(e);
            end
            if (k < hi) exp_err = 1'b1;
        end
    endtask

    task automatic gen_random(input int nr, input int nc, input int mode);
        int n = 0;
        int idx;
        logic [31:0] tmp;
        clear_mem();
        for (int i = 0; i < 64; i++) val_mem[i] = $urandom;
        for (int r = 0; r < nr; r++) begin
            row_mem[r] = n;
            for (int c = 0; c < nc; c++) begin
                if ($urandom_range(0, 99) < 40) begin
                    col_mem[n] = c;
                    val_mem[n] = $urandom | 32'd1;
                    n++;
                end
            end
        end
        row_mem[nr] = n;
        if (mode == 1 && n > 0) begin
            idx = $urandom_range(0, n - 1);
            col_mem[idx] = nc + $urandom_range(0, 5);
        end else if (mode == 2 && n > 1) begin
            idx = $urandom_range(0, n - 2);
            tmp = col_mem[idx];
            col_mem[idx] = col_mem[idx+1];
            col_mem[idx+1] = tmp;
        end else if (mode == 3 && nr > 1) begin
            idx = $urandom_range(1, nr - 1);
            row_mem[idx] = row_mem[idx+1] + 32'd1;
        end
    endtask

    // Starts a decode and records every handshake until done plus a short tail
    task automatic run_decode(input int nr, input int nc, input bit rand_ready, input bit extra_start);
        elem_t cur, prv;
        bit    stall_pend = 1'b0;
        int    cyc = 0;
        int    post = -1;
        obs_q.delete();
        done_cnt = 0; done_cyc = -1; done_hs = -1; stall_bad = 0;
        timed_out = 1'b0; busy_at_done = 1'b0;
        prv = '0;
        @(negedge clk);
        i_n_rows = 10'(nr);
        i_n_cols = 10'(nc);
        i_start  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (post < 4) begin
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
            if (extra_start && cyc == 3) begin
                i_start  = 1'b1;
                i_n_rows = 10'd1;
            end
            if (extra_start && cyc == 4) begin
                i_start  = 1'b0;
                i_n_rows = 10'(nr);
            end
            cur.data = o_out_data;
            cur.row  = o_out_row;
            cur.col  = o_out_col;
            cur.zero = o_out_zero;
            if (stall_pend && !(o_out_valid && cur == prv)) stall_bad++;
            i_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_out_valid && i_out_ready) obs_q.push_back(cur);
            stall_pend = o_out_valid && !i_out_ready;
            prv = cur;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    done_hs = obs_q.size();
                    busy_at_done = o_busy;
                    post = 0;
                end
            end else if (post >= 0) begin
                post++;
            end
            @(negedge clk);
            cyc++;
        end
        busy_after = o_busy;
        i_out_ready = 1'b1;
        $display("decode %0dx%0d elems=%0d err=%0b done_cyc=%0d", nr, nc, obs_q.size(), o_err, done_cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_out_valid); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", o_done); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", o_err); end
        checks++; if (o_out_zero !== 1'b0) begin failures++; $display("FAIL reset_zero: got %b expected 0", o_out_zero); end
        checks++;
        if (o_row_addr !== 14'd0 || o_col_addr !== 14'd0 || o_val_addr !== 14'd0) begin
            failures++; $display("FAIL reset_addr: got %0h/%0h/%0h expected 0/0/0", o_row_addr, o_col_addr, o_val_addr);
        end
        checks++;
        if (o_out_data !== 32'd0 || o_out_row !== 10'd0 || o_out_col !== 10'd0) begin
            failures++; $display("FAIL reset_out: got %0h (%0d,%0d) expected 0 (0,0)", o_out_data, o_out_row, o_out_col);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset sequence complete");
    endtask

    task automatic test_spec_matrix();
        int gold [9] = '{5, 0, 0, 0, 0, 7, 0, 0, 0};
        load_spec();
        build_expected(3, 3);
        run_decode(3, 3, 1'b0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL spec_timeout: got no done expected done"); end
        checks++; if (obs_q.size() != 9) begin failures++; $display("FAIL spec_len: got %0d expected 9", obs_q.size()); end
        for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].data !== 32'(gold[i]) || obs_q[i].zero !== (gold[i] == 0)) begin
                failures++;
                $display("FAIL spec_elem[%0d]: got %0d (%0d,%0d) z=%0b expected %0d (%0d,%0d) z=%0b", i,
                         obs_q[i].data, obs_q[i].row, obs_q[i].col, obs_q[i].zero,
                         gold[i], exp_q[i].row, exp_q[i].col, exp_q[i].zero);
            end
        end
        checks++; if (done_hs != 9) begin failures++; $display("FAIL spec_done_after: got %0d handshakes expected 9", done_hs); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL spec_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
            failures++; $display("FAIL spec_busy: got %b/%b expected 1/0", busy_at_done, busy_after);
        end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL spec_err: got %b expected 0", o_err); end
    endtask

    task automatic test_stall();
        load_spec();
        build_expected(3, 3);
        run_decode(3, 3, 1'b1, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL stall_timeout: got no done expected done"); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stall_elem[%0d]: got %0h (%0d,%0d) z=%0b expected %0h (%0d,%0d) z=%0b", i,
                         obs_q[i].data, obs_q[i].row, obs_q[i].col, obs_q[i].zero,
                         exp_q[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].zero);
            end
        end
        checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_hold: got %0d changes expected 0", stall_bad); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL stall_err: got %b expected 0", o_err); end
    endtask

    task automatic test_unsorted();
        clear_mem();
        row_mem[0] = 32'd0; row_mem[1] = 32'd2;
        col_mem[0] = 32'd1; col_mem[1] = 32'd0;
        val_mem[0] = 32'h0000_1234; val_mem[1] = 32'h0000_0099;
        build_expected(1, 2);
        run_decode(1, 2, 1'b0, 1'b0);
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL unsorted_len: got %0d expected 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            checks++;
            if (obs_q[0].data !== 32'd0 || obs_q[0].zero !== 1'b1 || obs_q[0].col !== 10'd0) begin
                failures++; $display("FAIL unsorted_e0: got %0h z=%0b c=%0d expected 0 z=1 c=0", obs_q[0].data, obs_q[0].zero, obs_q[0].col);
            end
            checks++;
            if (obs_q[1].data !== 32'h1234 || obs_q[1].zero !== 1'b0 || obs_q[1] !== exp_q[1]) begin
                failures++; $display("FAIL unsorted_e1: got %0h z=%0b c=%0d expected 1234 z=0 c=1", obs_q[1].data, obs_q[1].zero, obs_q[1].col);
            end
        end
        checks++; if (o_err !== 1'b1 || exp_err !== 1'b1) begin failures++; $display("FAIL unsorted_err: got %b expected 1", o_err); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL unsorted_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        load_spec();
        build_expected(3, 3);
        @(negedge clk);
        i_n_rows = 10'd3; i_n_cols = 10'd3; i_start = 1'b1; i_out_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            if (o_out_valid && o_out_row == 10'd1 && o_out_col == 10'd1) hit = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!hit) begin failures++; $display("FAIL midreset_reach: got no row-1 element expected one"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b expected 0", o_out_valid); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", o_busy); end
        @(posedge clk); #1;
        checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL midreset_hold: got %b expected 0", o_out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        run_decode(3, 3, 1'b0, 1'b0);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL midreset_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midreset_elem[%0d]: got %0h (%0d,%0d) expected %0h (%0d,%0d)", i,
                         obs_q[i].data, obs_q[i].row, obs_q[i].col, exp_q[i].data, exp_q[i].row, exp_q[i].col);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL midreset_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_zero_dims();
        load_spec();
        run_decode(0, 3, 1'b0, 1'b0);
        checks++; if (done_cyc < 0 || done_cyc > 1) begin failures++; $display("FAIL zero_rows_latency: got %0d expected <=1", done_cyc); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL zero_rows_elems: got %0d expected 0", obs_q.size()); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_rows_done: got %0d expected 1", done_cnt); end
        run_decode(2, 0, 1'b0, 1'b0);
        checks++; if (done_cyc < 0 || done_cyc > 1) begin failures++; $display("FAIL zero_cols_latency: got %0d expected <=1", done_cyc); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL zero_cols_elems: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_busy_start();
        load_spec();
        build_expected(3, 3);
        run_decode(3, 3, 1'b0, 1'b1);
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL busy_start_done: got %0d expected 1", done_cnt); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL busy_start_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL busy_start_elem[%0d]: got %0h (%0d,%0d) expected %0h (%0d,%0d)", i,
                         obs_q[i].data, obs_q[i].row, obs_q[i].col, exp_q[i].data, exp_q[i].row, exp_q[i].col);
            end
        end
    endtask

    task automatic test_random();
        int nr, nc;
        for (int t = 0; t < 12; t++) begin
            nr = $urandom_range(1, 4);
            nc = $urandom_range(1, 5);
            gen_random(nr, nc, t % 4);
            build_expected(nr, nc);
            run_decode(nr, nc, 1'b1, 1'b0);
            checks++; if (timed_out) begin failures++; $display("FAIL rand%0d_timeout: got no done expected done", t); end
            checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_len: got %0d expected %0d", t, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand%0d_elem[%0d]: got %0h (%0d,%0d) z=%0b expected %0h (%0d,%0d) z=%0b", t, i,
                             obs_q[i].data, obs_q[i].row, obs_q[i].col, obs_q[i].zero,
                             exp_q[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].zero);
                end
            end
            checks++; if (o_err !== exp_err) begin failures++; $display("FAIL rand%0d_err: got %b expected %b", t, o_err, exp_err); end
            checks++; if (stall_bad != 0) begin failures++; $display("FAIL rand%0d_hold: got %0d changes expected 0", t, stall_bad); end
            checks++; if (done_cnt != 1) begin failures++; $display("FAIL rand%0d_done: got %0d expected 1", t, done_cnt); end
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_spec_matrix();
        test_stall();
        test_unsorted();
        test_reset_mid();
        test_zero_dims();
        test_busy_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_decoder.md
CSR_DECODER -- requirements
Module: csr_decoder

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning the width of value, column and row-pointer words.
REQ-002 SHALL provide parameter ADDR_W, default 14, meaning the RAM address width.
REQ-003 SHALL provide parameter DIM_W, default 10, meaning the width of row and column indices.
REQ-004 SHALL have ports as listed:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin decode; sampled in IDLE only.
- n_rows, n_cols  in  DIM_W  matrix dimensions, latched on start.
- row_addr  out  ADDR_W  row-pointer RAM read address.
- row_dout  in  DATA_W  row-pointer RAM data.
- col_addr  out  ADDR_W  column-index RAM read address.
- col_dout  in  DATA_W  column-index RAM data.
- val_addr  out  ADDR_W  value RAM read address.
- val_dout  in  DATA_W  value RAM data.
- out_data  out  DATA_W  dense element value.
- out_row, out_col  out  DIM_W  element coordinates.
- out_zero  out  1  element is an implicit zero.
- out_valid  out  1  element present.
- out_ready  in  1  consumer accepts.
- busy  out  1  decode in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky malformed-CSR flag.

Function
REQ-005 SHALL expand CSR storage (row_ptr, col, val) into a row-major dense stream of n_rows*n_cols elements.
REQ-006 SHALL treat all RAM reads as one-cycle synchronous: data is valid the cycle after the address.
REQ-007 SHALL implement the FSM states IDLE, PTR_LO, PTR_HI, FETCH, WAIT, EMIT, NEXT_ROW and FIN.
REQ-008 SHALL move IDLE->PTR_LO on start while idle and latch n_rows and n_cols; start while busy SHALL be ignored.
REQ-009 SHALL read row_ptr[r] into k in PTR_LO+1 and row_ptr[r+1] into hi in PTR_HI+1.
REQ-010 SHALL, when k<hi, issue col_addr=val_addr=k (FETCH), capture both in WAIT, then enter EMIT.
REQ-011 SHALL in EMIT, for column c, output val[k] with out_zero=0 if the entry is live and col[k]==c; k SHALL increment on handshake, followed by FETCH/WAIT for the next entry (2-cycle bubble).
REQ-012 SHALL otherwise output 0 with out_zero=1; consecutive zeros SHALL stream one per cycle while out_ready=1.
REQ-013 SHALL treat a handshake as out_valid&&out_ready; out_data, out_row, out_col and out_zero SHALL be held stable while out_valid&&!out_ready.
REQ-014 SHALL, after c==n_cols-1 is handshaken, go to NEXT_ROW (r++), then PTR_LO, or FIN if r==n_rows-1.
REQ-015 SHALL, in FIN, pulse done for 1 cycle, deassert busy and return to IDLE.
REQ-016 SHALL assert busy from the cycle after start through FIN inclusive.
REQ-017 SHALL set err and treat the row as empty on hi<k.
REQ-018 SHALL set err and skip the entry (k++, refetch, no output) on col[k]<c (unsorted or duplicate).
REQ-019 SHALL set err, drop the leftover entries and proceed on col[k]>=n_cols or entries remaining at row end.
REQ-020 SHALL clear err only on start or reset.
REQ-021 SHALL, on n_rows==0 or n_cols==0, go IDLE->FIN directly with done=1 and no elements.
REQ-022 SHALL compare k and hi at ADDR_W bits, truncating the upper DATA_W bits of row_dout.

Reset
REQ-023 SHALL on reset low immediately force state=IDLE; out_valid, busy, done, err, out_zero=0; all addresses, out_data, out_row, out_col, r, c, k, hi=0.
REQ-024 SHALL abort an in-flight decode on reset without emitting further elements; the first start after release SHALL begin a fresh decode.

Structure
REQ-025 SHALL define the FSM state encoding and the DATA_W/ADDR_W/DIM_W defaults in the shared sparse-matrix package.
REQ-026 SHALL be a single module, with an optional sub-module csr_out_reg holding the output register/handshake stage.

Verification
REQ-027 SHALL cover 3x3 [[5,0,0],[0,0,7],[0,0,0]], row_ptr{0,1,2,2}, col{0,2}, val{5,7}, ready=1 -> 5,0,0,0,0,7,0,0,0; out_zero=0 only at (0,0),(1,2); done after the 9th handshake; err=0.
REQ-028 SHALL cover the same matrix with out_ready toggled 1/0 pseudo-randomly -> identical sequence, outputs stable during stalls, no loss or duplication.
REQ-029 SHALL cover row_ptr{0,2}, col{1,0}, 1x2 -> err=1, (0,0)=0, (0,1)=val[0], done asserted.
REQ-030 SHALL cover reset low mid-row 1 of REQ-027 -> out_valid=0 and busy=0 immediately; a restart yields the full 9-element sequence.
REQ-031 SHALL cover start with n_rows=0 -> done pulse within 2 cycles, zero handshakes.
REQ-032 SHALL cover start pulsed while busy -> ignored; a single done pulse.
